axi_4k_mtu_splitter: RTL

Parametrised request splitter between the submaster grant arbiter and the 4 KB-aligned transaction RAM. It accepts one AXI read/write request at a time, described by start address, byte count, granted channel and direction. It emits a sequence of sub-requests, each of which never crosses a 4 KB boundary and never exceeds MAX_MTU bytes. Each sub-request is handed over on a valid/ready handshake with first/last markers and the channel and direction tags attached.

---
 rtl/axi_4k_mtu_splitter_if.sv | 42 ++++
 rtl/axi_4k_mtu_splitter.sv | 94 +++++++++
 2 files changed

// File: rtl/axi_4k_mtu_splitter_if.sv
// Request/sub-request bundle between the grant arbiter, the splitter and the transaction RAM.
// master = requester and sub-request consumer side, slave = splitter side.
interface axi_4k_mtu_splitter_if #(
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 16,
  parameter int MAX_MTU = 256,
  parameter int NUM_CH  = 8
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MTU_W = $clog2(MAX_MTU) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_bytes;
  logic [CH_W-1:0]   req_ch;
  logic              req_wr;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [MTU_W-1:0]  out_bytes;
  logic [CH_W-1:0]   out_ch;
  logic              out_wr;
  logic              out_first;
  logic              out_last;

  logic              busy;
  logic              err_zero;

  modport master (
    output req_valid, req_addr, req_bytes, req_ch, req_wr, out_ready,
    input  req_ready, out_valid, out_addr, out_bytes, out_ch, out_wr,
           out_first, out_last, busy, err_zero
  );

  modport slave (
    input  req_valid, req_addr, req_bytes, req_ch, req_wr, out_ready,
    output req_ready, out_valid, out_addr, out_bytes, out_ch, out_wr,
           out_first, out_last, busy, err_zero
  );
endinterface

// File: rtl/axi_4k_mtu_splitter.sv
// Splits one request into sub-requests that never cross a 4 KB page nor exceed MAX_MTU bytes.
// Accept at edge N gives out_valid in N+1; one sub-request per cycle; outputs hold while out_ready=0.
module axi_4k_mtu_splitter #(
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 16,
  parameter int MAX_MTU = 256,
  parameter int NUM_CH  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  axi_4k_mtu_splitter_if.slave   bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MTU_W = $clog2(MAX_MTU) + 1;
  localparam int CW    = 33;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [CH_W-1:0]   ch_q;
  logic              wr_q;
  logic              first_q;
  logic              err_q;

  logic [12:0]       to_bound;
  logic [CW-1:0]     rem_ext;
  logic [CW-1:0]     bnd_ext;
  logic [MTU_W-1:0]  cap;
  logic [MTU_W-1:0]  chunk;
  logic              last;

  // Chunk is derived purely from registered state so outputs stay stable under backpressure.
  always_comb begin
    to_bound = 13'h1000 - {1'b0, cur_addr[11:0]};
    rem_ext  = CW'(remaining);
    bnd_ext  = CW'(to_bound);
    cap      = (rem_ext > CW'(MAX_MTU)) ? MTU_W'(MAX_MTU) : MTU_W'(remaining);
    chunk    = (bnd_ext < CW'(cap)) ? MTU_W'(to_bound) : cap;
    last     = (CW'(chunk) == rem_ext);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      ch_q      <= '0;
      wr_q      <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_bytes == '0) begin
              err_q <= 1'b1;
            end else begin
              cur_addr  <= bus.req_addr;
              remaining <= bus.req_bytes;
              ch_q      <= bus.req_ch;
              wr_q      <= bus.req_wr;
              first_q   <= 1'b1;
              state     <= SPLIT;
            end
          end
        end
        SPLIT: begin
          if (bus.out_ready) begin
            // Address wraps modulo 2^ADDR_W by natural overflow.
            cur_addr  <= cur_addr + ADDR_W'(chunk);
            remaining <= remaining - LEN_W'(chunk);
            first_q   <= 1'b0;
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state == SPLIT);
  assign bus.out_valid = (state == SPLIT);
  assign bus.out_addr  = cur_addr;
  assign bus.out_bytes = (state == SPLIT) ? chunk : '0;
  assign bus.out_last  = (state == SPLIT) & last;
  assign bus.out_first = first_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_wr    = wr_q;
  assign bus.err_zero  = err_q;
endmodule
